// File: rtl/ram_access_controller.sv
// ----------------------------------------------------------------------------
// ram_access_controller
//
// Owns the single write/address port of the program RAM and shares it
// between three requesters, highest priority first:
//   1. the internal boot sequencer, which copies one program ROM image into
//      RAM word by word,
//   2. manual programming from the board switches (one word per button press),
//   3. the running CPU (zero-latency passthrough).
// The CPU is held off the bus during loads and manual programming and is
// released with a one-cycle reset pulse after a load.
//
// Ports:
//   clk, rst_n                 system clock, asynchronous active-low reset
//   enable_bootloader          board input; rising edge starts a load
//   bootloader_switches        program select, latched when a load starts
//   ram_mode                   board input; 1 selects manual programming
//   ram_pulse                  debounced pushbutton; one write per rising edge
//   mar_switches, ram_switches manual address / data
//   cpu_addr, cpu_wdata, cpu_we  CPU side of the RAM port
//   rom_addr / rom_data        program ROM, {prog, idx}; data 1 cycle later
//   ram_addr, ram_wdata, ram_we  RAM write/address port
//   cpu_hold                   freezes the CPU clock enable
//   cpu_reset                  one-cycle CPU reset request after a load
//   boot_busy, boot_done       load in progress / load complete
// ----------------------------------------------------------------------------
module ram_access_controller #(
    parameter int ADDR_WIDTH     = 4,
    parameter int DATA_WIDTH     = 8,
    parameter int PROG_SEL_WIDTH = 4,
    parameter int SYNC_STAGES    = 2   // must be at least 2
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               enable_bootloader,
    input  logic [PROG_SEL_WIDTH-1:0]          bootloader_switches,
    input  logic                               ram_mode,
    input  logic                               ram_pulse,
    input  logic [ADDR_WIDTH-1:0]              mar_switches,
    input  logic [DATA_WIDTH-1:0]              ram_switches,
    input  logic [ADDR_WIDTH-1:0]              cpu_addr,
    input  logic [DATA_WIDTH-1:0]              cpu_wdata,
    input  logic                               cpu_we,
    output logic [PROG_SEL_WIDTH+ADDR_WIDTH-1:0] rom_addr,
    input  logic [DATA_WIDTH-1:0]              rom_data,
    output logic [ADDR_WIDTH-1:0]              ram_addr,
    output logic [DATA_WIDTH-1:0]              ram_wdata,
    output logic                               ram_we,
    output logic                               cpu_hold,
    output logic                               cpu_reset,
    output logic                               boot_busy,
    output logic                               boot_done
);

    localparam logic [ADDR_WIDTH-1:0] IDX_LAST = '1;

    typedef enum logic [2:0] {
        ST_RUN,
        ST_MANUAL,
        ST_BOOT_FETCH,
        ST_BOOT_WRITE,
        ST_BOOT_HOLD
    } state_e;

    // Board-input synchronizers; the oldest stage is the synchronized value.
    logic [SYNC_STAGES-1:0] enable_sync_q, enable_sync_d;
    logic [SYNC_STAGES-1:0] mode_sync_q,   mode_sync_d;
    logic [SYNC_STAGES-1:0] pulse_sync_q,  pulse_sync_d;
    logic                   enable_s, ram_mode_s, ram_pulse_s;

    // Edge-detect history. Resetting these to 0 makes a level that is already
    // high at reset release look like a rising edge.
    logic enable_prev_q, enable_prev_d;
    logic pulse_prev_q,  pulse_prev_d;
    logic enable_rise, pulse_rise;

    state_e                                state_q, state_d;
    logic [ADDR_WIDTH-1:0]                 idx_q, idx_d;
    logic [ADDR_WIDTH-1:0]                 idx_inc;
    logic [PROG_SEL_WIDTH-1:0]             prog_q, prog_d;
    logic [PROG_SEL_WIDTH+ADDR_WIDTH-1:0]  rom_addr_q, rom_addr_d;
    logic                                  cpu_reset_q, cpu_reset_d;
    logic                                  load_start;
    logic                                  ram_we_int;

    assign enable_s    = enable_sync_q[SYNC_STAGES-1];
    assign ram_mode_s  = mode_sync_q[SYNC_STAGES-1];
    assign ram_pulse_s = pulse_sync_q[SYNC_STAGES-1];

    assign enable_rise = enable_s & ~enable_prev_q;
    assign pulse_rise  = ram_pulse_s & ~pulse_prev_q;
    assign idx_inc     = idx_q + 1'b1;

    always_comb begin
        // NOTE: every variable gets a default before the case statement so no
        // path leaves one unassigned, which would otherwise infer a latch.
        enable_sync_d = {enable_sync_q[SYNC_STAGES-2:0], enable_bootloader};
        mode_sync_d   = {mode_sync_q[SYNC_STAGES-2:0], ram_mode};
        pulse_sync_d  = {pulse_sync_q[SYNC_STAGES-2:0], ram_pulse};
        enable_prev_d = enable_s;
        pulse_prev_d  = ram_pulse_s;

        state_d     = state_q;
        idx_d       = idx_q;
        prog_d      = prog_q;
        rom_addr_d  = rom_addr_q;
        cpu_reset_d = 1'b0;
        load_start  = 1'b0;

        ram_addr    = idx_q;
        ram_wdata   = rom_data;
        ram_we_int  = 1'b0;

        unique case (state_q)
            ST_RUN: begin
                ram_addr   = cpu_addr;
                ram_wdata  = cpu_wdata;
                ram_we_int = cpu_we;
                if (enable_rise) begin
                    load_start = 1'b1;
                end else if (ram_mode_s) begin
                    state_d = ST_MANUAL;
                end
            end

            ST_MANUAL: begin
                ram_addr  = mar_switches;
                ram_wdata = ram_switches;
                // A load request wins; a pulse edge in the same cycle is dropped.
                if (enable_rise) begin
                    load_start = 1'b1;
                end else begin
                    ram_we_int = pulse_rise;
                    if (!ram_mode_s) begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_BOOT_FETCH: begin
                // rom_addr already holds {prog, idx}; the ROM word appears next cycle.
                state_d = ST_BOOT_WRITE;
            end

            ST_BOOT_WRITE: begin
                ram_we_int = 1'b1;
                if (idx_q == IDX_LAST) begin
                    state_d = ST_BOOT_HOLD;
                end else begin
                    idx_d      = idx_inc;
                    rom_addr_d = {prog_q, idx_inc};
                    state_d    = ST_BOOT_FETCH;
                end
            end

            ST_BOOT_HOLD: begin
                if (!enable_s) begin
                    cpu_reset_d = 1'b1;
                    state_d     = ram_mode_s ? ST_MANUAL : ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // The ROM address is registered on entry to the first fetch so the
        // word is already on rom_data when the matching write cycle arrives.
        if (load_start) begin
            prog_d     = bootloader_switches;
            idx_d      = '0;
            rom_addr_d = {bootloader_switches, {ADDR_WIDTH{1'b0}}};
            state_d    = ST_BOOT_FETCH;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples its _d value from before this edge, independent of order.
        if (!rst_n) begin
            enable_sync_q <= '0;
            mode_sync_q   <= '0;
            pulse_sync_q  <= '0;
            enable_prev_q <= 1'b0;
            pulse_prev_q  <= 1'b0;
            state_q       <= ST_RUN;
            idx_q         <= '0;
            prog_q        <= '0;
            rom_addr_q    <= '0;
            cpu_reset_q   <= 1'b0;
        end else begin
            enable_sync_q <= enable_sync_d;
            mode_sync_q   <= mode_sync_d;
            pulse_sync_q  <= pulse_sync_d;
            enable_prev_q <= enable_prev_d;
            pulse_prev_q  <= pulse_prev_d;
            state_q       <= state_d;
            idx_q         <= idx_d;
            prog_q        <= prog_d;
            rom_addr_q    <= rom_addr_d;
            cpu_reset_q   <= cpu_reset_d;
        end
    end

    // The RUN passthrough is combinational, so the write strobe is gated by
    // reset directly to keep the RAM safe while rst_n is low.
    assign ram_we    = ram_we_int & rst_n;
    assign rom_addr  = rom_addr_q;
    assign cpu_reset = cpu_reset_q;
    assign cpu_hold  = (state_q != ST_RUN);
    assign boot_busy = (state_q == ST_BOOT_FETCH) || (state_q == ST_BOOT_WRITE);
    assign boot_done = (state_q == ST_BOOT_HOLD);

endmodule

// File: doc/ram_access_controller.md
Name: ram_access_controller

Overview:
Owns the single write/address port of the 16x8 program RAM and shares it between three requesters: the boot sequencer (internal), manual switch programming, and the running CPU. When a bootloader load is triggered, it walks the selected program ROM image into RAM word by word. It holds the CPU off the bus during loads and manual programming, then releases it with a one-cycle reset pulse. It sits between the top level's board inputs, the program ROM, the CPU's MAR/RAM interface and the RAM module.

Parameters:
ADDR_WIDTH, 4, RAM address width; RAM depth is 2**ADDR_WIDTH.
DATA_WIDTH, 8, RAM/ROM word width.
PROG_SEL_WIDTH, 4, width of the program select field.
SYNC_STAGES, 2, flops per board-input synchronizer; minimum 2.

Ports:
clk  in  1  system clock.
rst_n  in  1  asynchronous active-low reset.
enable_bootloader  in  1  board level input; a rising edge starts a load.
bootloader_switches  in  PROG_SEL_WIDTH  program select; latched when a load starts.
ram_mode  in  1  board level input; 1 selects manual programming.
ram_pulse  in  1  debounced board pushbutton; each rising edge writes one word.
mar_switches  in  ADDR_WIDTH  manual address.
ram_switches  in  DATA_WIDTH  manual data.
cpu_addr  in  ADDR_WIDTH  CPU MAR value.
cpu_wdata  in  DATA_WIDTH  CPU write data.
cpu_we  in  1  CPU RAM write enable.
rom_addr  out  PROG_SEL_WIDTH+ADDR_WIDTH  program ROM address, {prog, idx}.
rom_data  in  DATA_WIDTH  program ROM data; valid 1 cycle after rom_addr.
ram_addr  out  ADDR_WIDTH  RAM address.
ram_wdata  out  DATA_WIDTH  RAM write data.
ram_we  out  1  RAM write enable.
cpu_hold  out  1  freezes the CPU clock enable.
cpu_reset  out  1  one-cycle CPU reset request.
boot_busy  out  1  load in progress.
boot_done  out  1  load complete; waiting for enable_bootloader to fall.

Behaviour:
- Synchronization and edges:
  - enable_bootloader, ram_mode and ram_pulse each pass through SYNC_STAGES flops.
  - All decisions and edge detection use the synchronized values (_s).
  - Edge registers reset to 0, so a level that is already high when reset releases counts as a rising edge.
- Reset values: state RUN, idx 0, prog 0, rom_addr 0, cpu_hold 0, cpu_reset 0, boot_busy 0, boot_done 0.
  - ram_we is forced to 0 while rst_n is low.
  - ram_addr and ram_wdata follow the RUN mux.
- States: RUN, MANUAL, BOOT_FETCH, BOOT_WRITE, BOOT_HOLD. Priority order: boot, then manual, then CPU.
- RUN:
  - ram_addr/ram_wdata/ram_we = cpu_addr/cpu_wdata/cpu_we, combinational with zero latency; cpu_hold 0.
  - On a rising edge of enable_s: latch prog = bootloader_switches, set idx = 0, go to BOOT_FETCH.
  - Otherwise, if ram_mode_s is 1, go to MANUAL.
- MANUAL:
  - cpu_hold 1; ram_addr = mar_switches; ram_wdata = ram_switches.
  - ram_we is high for exactly one cycle per ram_pulse_s rising edge, regardless of how long the button is held.
  - On a rising edge of enable_s, go to BOOT_FETCH; this has priority over a simultaneous pulse edge, which is dropped.
  - Otherwise, if ram_mode_s is 0, go to RUN.
- BOOT_FETCH:
  - Register rom_addr = {prog, idx}; cpu_hold 1; boot_busy 1; ram_we 0.
  - Next state is BOOT_WRITE.
- BOOT_WRITE:
  - ram_we 1; ram_addr = idx; ram_wdata = rom_data.
  - If idx == 2**ADDR_WIDTH-1, go to BOOT_HOLD; otherwise idx++ and go to BOOT_FETCH.
  - Each word takes 2 cycles; a full load takes 32 cycles at the defaults.
- BOOT_HOLD:
  - boot_busy 0; boot_done 1; cpu_hold 1; ram_we 0.
  - When enable_s falls, go to MANUAL if ram_mode_s is 1, else RUN.
  - cpu_reset is high for exactly the first cycle in the new state.
- Loads run to completion once started:
  - enable_s falling, rising edges of enable_s, ram_mode_s, ram_pulse_s and changes to bootloader_switches are all ignored during BOOT_FETCH/BOOT_WRITE.
  - cpu_we is ignored outside RUN.
- Reset mid-load: immediate return to reset values; the partial program stays in RAM; no further writes occur.
- idx wraps only through the terminal-count compare; it never increments past 2**ADDR_WIDTH-1.

Test Plan:
1. RUN passthrough: after reset, drive cpu_addr=5, cpu_wdata=0xA3, cpu_we=1 -> same cycle ram_addr=5, ram_wdata=0xA3, ram_we=1, cpu_hold=0.
2. Full load:
   - Stimulus: switches=3, raise enable_bootloader, ROM model returns data = 0x30+idx.
   - Required: rom_addr steps 0x30..0x3F; exactly 16 ram_we cycles at addr 0..15 with data 0x30..0x3F; boot_done 32 cycles after the edge.
   - Then lower enable_bootloader -> one cpu_reset cycle, RUN.
3. Manual write: ram_mode=1, mar=7, ram_switches=0x5C, hold ram_pulse for 10 cycles -> exactly one ram_we cycle at addr 7 with data 0x5C; cpu_hold=1 throughout.
4. Priority:
   - In MANUAL, raise enable_bootloader and ram_pulse on the same cycle -> load starts and no manual write occurs.
   - After the load, with ram_mode still 1 and enable lowered -> MANUAL.
5. Reset mid-load: assert rst_n=0 at idx 6 -> ram_we=0 and cpu_hold=0 immediately; after release, state is RUN and no writes occur.
6. Select change mid-load: switches 3 -> 9 at idx 4 -> rom_addr upper nibble stays 3 until boot_done.
